// File: rtl/data_mem_scan_pkg.sv
// data_mem_pkg: shared definitions for data_mem_scan.
//   - scan_state_e : scan FSM state encoding
//   - SCAN_MODE_*  : bit positions inside scan_mode
//   - log2()       : word-index width for a power-of-two DEPTH
package data_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_e;

  localparam int SCAN_MODE_MAX_BIT    = 0;
  localparam int SCAN_MODE_SIGNED_BIT = 1;

  // Smallest w with 2**w >= value.
  function automatic int log2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/data_mem_scan_if.sv
// data_mem_scan_if: CPU load/store port plus scan engine control/result.
//   master : CPU / scan requester side (drives adr, write_data, mem_read,
//            mem_write, scan_start, scan_base, scan_count, scan_mode)
//   slave  : memory side (drives read_data, scan_busy, scan_done,
//            scan_value, scan_index)
interface data_mem_scan_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] read_data;

  logic                  scan_start;
  logic [ADDR_WIDTH-1:0] scan_base;
  logic [CNT_WIDTH-1:0]  scan_count;
  logic [1:0]            scan_mode;
  logic                  scan_busy;
  logic                  scan_done;
  logic [DATA_WIDTH-1:0] scan_value;
  logic [CNT_WIDTH-1:0]  scan_index;

  modport master (
    output adr, write_data, mem_read, mem_write,
    output scan_start, scan_base, scan_count, scan_mode,
    input  read_data, scan_busy, scan_done, scan_value, scan_index
  );

  modport slave (
    input  adr, write_data, mem_read, mem_write,
    input  scan_start, scan_base, scan_count, scan_mode,
    output read_data, scan_busy, scan_done, scan_value, scan_index
  );

endinterface

// File: rtl/data_mem_scan_fsm.sv
// array_scan_fsm: min (optionally max) finder over N consecutive words.
// Reads one element per cycle through a dedicated read port of the array.
// Optional feature macro: DATA_MEM_SCAN_MAX_EN (enables max search via
// mode_i[SCAN_MODE_MAX_BIT]; otherwise minimum only).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start_i            scan request (accepted in IDLE only)
//   base_i/count_i     first word index / element count N
//   mode_i             bit0 max select, bit1 signed compare
//   rd_addr_o/rd_data_i combinational read port into the array
//   busy_o/done_o      scan in progress / one-cycle completion pulse
//   value_o/index_o    best value and its offset from base
//
// state  | meaning
// S_IDLE | waiting for start_i
// S_SCAN | comparing element cur_q, one per cycle
// S_DONE | publishing result; done_o pulses on the exit edge
module array_scan_fsm
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int IDX_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [IDX_WIDTH-1:0]  base_i,
  input  logic [CNT_WIDTH-1:0]  count_i,
  input  logic [1:0]            mode_i,
  output logic [IDX_WIDTH-1:0]  rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] value_o,
  output logic [CNT_WIDTH-1:0]  index_o
);

  scan_state_e           state_q;
  logic [IDX_WIDTH-1:0]  base_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cur_q;
  logic                  signed_q;
  logic [DATA_WIDTH-1:0] best_q;
  logic [CNT_WIDTH-1:0]  best_idx_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic [CNT_WIDTH-1:0]  index_q;

  logic better;
  logic is_less;

  // Offset is added in the word-index domain so the address wraps mod DEPTH.
  assign rd_addr_o = base_q + IDX_WIDTH'(cur_q);

  assign is_less = signed_q ? ($signed(rd_data_i) < $signed(best_q))
                            : (rd_data_i < best_q);

`ifdef DATA_MEM_SCAN_MAX_EN
  logic max_q;
  logic is_greater;

  assign is_greater = signed_q ? ($signed(rd_data_i) > $signed(best_q))
                               : (rd_data_i > best_q);
  assign better     = max_q ? is_greater : is_less;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= 1'b0;
    end else if (state_q == S_IDLE && start_i) begin
      max_q <= mode_i[SCAN_MODE_MAX_BIT];
    end
  end
`else
  logic unused_mode_max;

  assign unused_mode_max = mode_i[SCAN_MODE_MAX_BIT];
  assign better          = is_less;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      cur_q      <= '0;
      signed_q   <= 1'b0;
      best_q     <= '0;
      best_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      value_q    <= '0;
      index_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            base_q     <= base_i;
            cnt_q      <= count_i;
            signed_q   <= mode_i[SCAN_MODE_SIGNED_BIT];
            cur_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            if (count_i == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_SCAN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          // Strict compare: ties keep the earlier (lower) offset.
          if (cur_q == '0 || better) begin
            best_q     <= rd_data_i;
            best_idx_q <= cur_q;
          end
          cur_q <= cur_q + CNT_WIDTH'(1);
          if (cur_q == cnt_q - CNT_WIDTH'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          value_q <= best_q;
          index_q <= best_idx_q;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign value_o = value_q;
  assign index_o = index_q;

endmodule

// File: rtl/data_mem_scan.sv
// data_mem_scan: word-organised data RAM for the single-cycle CPU with an
// array min/max scan engine on a dedicated read port.
// Optional feature macro: DATA_MEM_SCAN_MAX_EN (max search via scan_mode[0]).
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (RAM contents are not reset)
//   bus  data_mem_scan_if.slave: CPU load/store port and scan control/result
module data_mem_scan
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_scan_if.slave  bus
);

  localparam int IDX_W = log2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]      cpu_idx;
  logic [IDX_W-1:0]      scan_base_idx;
  logic [IDX_W-1:0]      scan_rd_idx;
  logic [DATA_WIDTH-1:0] scan_rd_data;
  logic                  unused_addr;

  // Byte address -> word index; upper bits beyond DEPTH alias (mod DEPTH).
  assign cpu_idx       = bus.adr[IDX_W+1:2];
  assign scan_base_idx = bus.scan_base[IDX_W+1:2];
  assign unused_addr   = ^{bus.adr, bus.scan_base};

  always_ff @(posedge clk) begin
    if (bus.mem_write) begin
      mem_q[cpu_idx] <= bus.write_data;
    end
  end

  // Both read ports are combinational, so a same-cycle write is not yet visible.
  assign bus.read_data = bus.mem_read ? mem_q[cpu_idx] : '0;
  assign scan_rd_data  = mem_q[scan_rd_idx];

  array_scan_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .IDX_WIDTH  (IDX_W)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .start_i   (bus.scan_start),
    .base_i    (scan_base_idx),
    .count_i   (bus.scan_count),
    .mode_i    (bus.scan_mode),
    .rd_addr_o (scan_rd_idx),
    .rd_data_i (scan_rd_data),
    .busy_o    (bus.scan_busy),
    .done_o    (bus.scan_done),
    .value_o   (bus.scan_value),
    .index_o   (bus.scan_index)
  );

endmodule

// File: tb/tb_data_mem_scan.sv
module tb_data_mem_scan;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int CW    = 16;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  data_mem_scan_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus();

  data_mem_scan #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] model_mem [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // True when v should replace the current best b under the given mode.
  function automatic bit ref_better(input logic [DW-1:0] v, input logic [DW-1:0] b,
                                    input logic [1:0] mode);
    bit lt, gt;
    if (mode[1]) begin
      lt = $signed(v) < $signed(b);
      gt = $signed(v) > $signed(b);
    end else begin
      lt = v < b;
      gt = v > b;
    end
`ifdef DATA_MEM_SCAN_MAX_EN
    if (mode[0]) return gt;
`endif
    return lt;
  endfunction

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.adr        = a;
    bus.write_data = d;
    bus.mem_write  = 1'b1;
    @(negedge clk);
    bus.mem_write  = 1'b0;
    model_mem[word_of(a)] = d;
  endtask

  // Runs one scan. Optionally injects a second start at cycle 1 (must be
  // ignored) and a CPU write in cycle wr_c (visible to elements j > wr_c).
  task automatic run_scan(input string tag, input logic [AW-1:0] base, input int n,
                          input logic [1:0] mode, input bit inj, input bit wr_en,
                          input int wr_c, input logic [AW-1:0] wr_addr,
                          input logic [DW-1:0] wr_val);
    logic [DW-1:0] best, v;
    int bidx, k, busy_cnt, w, wr_word;
    bit got;
    wr_word = word_of(wr_addr);
    best = '0;
    bidx = 0;
    for (int j = 0; j < n; j++) begin
      w = int'(((base >> 2) + AW'(j)) % DEPTH);
      v = model_mem[w];
      if (wr_en && w == wr_word && j > wr_c) v = wr_val;
      if (j == 0 || ref_better(v, best, mode)) begin
        best = v;
        bidx = j;
      end
    end
    bus.scan_base  = base;
    bus.scan_count = CW'(n);
    bus.scan_mode  = mode;
    bus.scan_start = 1'b1;
    @(negedge clk);
    bus.scan_start = 1'b0;
    k = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (k <= n + 8) begin
      bus.mem_write = wr_en && (k == wr_c);
      if (bus.mem_write) begin
        bus.adr        = wr_addr;
        bus.write_data = wr_val;
      end
      bus.scan_start = inj && (k == 1);
      if (bus.scan_start) begin
        bus.scan_base  = $urandom;
        bus.scan_count = CW'($urandom_range(1, 5));
        bus.scan_mode  = ~mode;
      end
      if (bus.scan_done) begin
        got = 1'b1;
        break;
      end
      if (bus.scan_busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    bus.mem_write  = 1'b0;
    bus.scan_start = 1'b0;
    if (wr_en) model_mem[wr_word] = wr_val;
    check({tag, "/done_seen"}, 64'(got), 64'(1));
    check({tag, "/latency"}, 64'(k), 64'(n + 1));
    check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(n));
    check({tag, "/value"}, 64'(bus.scan_value), 64'(best));
    check({tag, "/index"}, 64'(bus.scan_index), 64'(bidx));
    @(negedge clk);
    check({tag, "/done_one_cycle"}, 64'(bus.scan_done), 64'(0));
    check({tag, "/value_held"}, 64'(bus.scan_value), 64'(best));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    logic [AW-1:0] rbase, waddr;
    int rn, rc;
    logic [1:0] rmode;
    bit rinj, rwr;

    bus.adr        = '0;
    bus.write_data = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.scan_start = 1'b0;
    bus.scan_base  = '0;
    bus.scan_count = '0;
    bus.scan_mode  = 2'b00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset/busy",  64'(bus.scan_busy),  64'(0));
    check("reset/done",  64'(bus.scan_done),  64'(0));
    check("reset/value", 64'(bus.scan_value), 64'(0));
    check("reset/index", 64'(bus.scan_index), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) cpu_write(AW'(i * 4), $urandom);

    // {7,3,9,3,5} unsigned min, then max-mode request
    cpu_write(32'h0, 32'd7);
    cpu_write(32'h4, 32'd3);
    cpu_write(32'h8, 32'd9);
    cpu_write(32'hC, 32'd3);
    cpu_write(32'h10, 32'd5);
    run_scan("min5", 32'h0, 5, 2'b00, 1'b0, 1'b0, 0, '0, '0);
    check("min5/const_value", 64'(bus.scan_value), 64'(3));
    check("min5/const_index", 64'(bus.scan_index), 64'(1));
    run_scan("mode_max5", 32'h0, 5, 2'b01, 1'b0, 1'b0, 0, '0, '0);
`ifdef DATA_MEM_SCAN_MAX_EN
    check("mode_max5/const_value", 64'(bus.scan_value), 64'(9));
    check("mode_max5/const_index", 64'(bus.scan_index), 64'(2));
`else
    check("mode_max5/const_value", 64'(bus.scan_value), 64'(3));
    check("mode_max5/const_index", 64'(bus.scan_index), 64'(1));
`endif

    // signed vs unsigned
    cpu_write(32'h0, 32'h0000_0002);
    cpu_write(32'h4, 32'hFFFF_FFFF);
    run_scan("umin2", 32'h0, 2, 2'b00, 1'b0, 1'b0, 0, '0, '0);
    check("umin2/const_value", 64'(bus.scan_value), 64'(32'h2));
    check("umin2/const_index", 64'(bus.scan_index), 64'(0));
    run_scan("smin2", 32'h0, 2, 2'b10, 1'b0, 1'b0, 0, '0, '0);
    check("smin2/const_value", 64'(bus.scan_value), 64'(32'hFFFF_FFFF));
    check("smin2/const_index", 64'(bus.scan_index), 64'(1));

    // wrap from word 1023 to word 0
    cpu_write(32'hFF8, 32'd8);
    cpu_write(32'hFFC, 32'd6);
    cpu_write(32'h0,   32'd1);
    run_scan("wrap3", 32'hFF8, 3, 2'b00, 1'b0, 1'b0, 0, '0, '0);
    check("wrap3/const_value", 64'(bus.scan_value), 64'(1));
    check("wrap3/const_index", 64'(bus.scan_index), 64'(2));

    // N = 0
    run_scan("n0", 32'h40, 0, 2'b00, 1'b0, 1'b0, 0, '0, '0);
    check("n0/const_value", 64'(bus.scan_value), 64'(0));

    // second start during a 4-element scan is ignored
    cpu_write(32'h0, 32'd7);
    cpu_write(32'h4, 32'd3);
    cpu_write(32'h8, 32'd9);
    cpu_write(32'hC, 32'd3);
    run_scan("ignore_start", 32'h0, 4, 2'b00, 1'b1, 1'b0, 0, '0, '0);
    check("ignore_start/const_value", 64'(bus.scan_value), 64'(3));

    // write ahead of scanner is seen; write to element under scan is not
    cpu_write(32'h10, 32'd5);
    run_scan("write_ahead", 32'h0, 5, 2'b00, 1'b0, 1'b1, 0, 32'h10, 32'd1);
    check("write_ahead/const_index", 64'(bus.scan_index), 64'(4));
    cpu_write(32'h10, 32'd5);
    run_scan("write_same", 32'h0, 5, 2'b00, 1'b0, 1'b1, 1, 32'h4, 32'd0);
    check("write_same/const_value", 64'(bus.scan_value), 64'(3));

    // CPU port
    cpu_write(32'h10, 32'h55);
    bus.adr = 32'h10;
    bus.mem_read = 1'b1;
    #1;
    check("cpu/lw_after_sw", 64'(bus.read_data), 64'(32'h55));
    bus.mem_read = 1'b0;
    #1;
    check("cpu/read_disabled", 64'(bus.read_data), 64'(0));
    bus.adr = 32'h20;
    bus.mem_read = 1'b1;
    bus.mem_write = 1'b1;
    bus.write_data = 32'hAB;
    #1;
    check("cpu/rw_pre_write", 64'(bus.read_data), 64'(model_mem[8]));
    @(negedge clk);
    bus.mem_write = 1'b0;
    model_mem[8] = 32'hAB;
    #1;
    check("cpu/rw_post_write", 64'(bus.read_data), 64'(32'hAB));
    bus.mem_read = 1'b0;
    @(negedge clk);

    // reset during a scan
    bus.scan_base = 32'h0;
    bus.scan_count = CW'(10);
    bus.scan_mode = 2'b00;
    bus.scan_start = 1'b1;
    @(negedge clk);
    bus.scan_start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid/busy_before", 64'(bus.scan_busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid/busy",  64'(bus.scan_busy),  64'(0));
    check("rst_mid/done",  64'(bus.scan_done),  64'(0));
    check("rst_mid/value", 64'(bus.scan_value), 64'(0));
    check("rst_mid/index", 64'(bus.scan_index), 64'(0));
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.scan_done) done_cnt++;
    end
    check("rst_mid/no_done", 64'(done_cnt), 64'(0));
    bus.adr = 32'h10;
    bus.mem_read = 1'b1;
    #1;
    check("rst_mid/mem_kept", 64'(bus.read_data), 64'(32'h55));
    bus.mem_read = 1'b0;
    @(negedge clk);

    // randomized scans against the reference model
    for (int it = 0; it < 30; it++) begin
      rbase = $urandom;
      rn    = $urandom_range(0, 24);
      rmode = 2'($urandom_range(0, 3));
      rinj  = (rn >= 1) && ($urandom_range(0, 1) == 1);
      rwr   = (rn >= 1) && ($urandom_range(0, 1) == 1);
      rc    = (rn >= 1) ? $urandom_range(0, rn - 1) : 0;
      waddr = rbase + AW'(4 * $urandom_range(0, rn));
      run_scan($sformatf("rand%0d", it), rbase, rn, rmode, rinj, rwr, rc, waddr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
